// File: rtl/ifu_ahb.sv
// ifu_ahb: AHB-Lite instruction fetch unit with an IFB_DEPTH-entry fetch buffer feeding decode.
// Define IFU_AHB_PERF_EN to add the perf_fetch_cnt / perf_kill_cnt counter outputs.
module ifu_ahb #(
    parameter int NINST     = 2,
    parameter int IFB_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         rst_vec,
    input  logic                ifu_take_jmp,
    input  logic [31:0]         ifu_jmp_addr,
    input  logic                use_out,
    output logic [NINST-1:0]    out_valid,
    output logic [32*NINST-1:0] out_inst,
    output logic [31:0]         out_addr,
    output logic                out_err,
    output logic [31:0]         imem_haddr,
    output logic [1:0]          imem_htrans,
    output logic [2:0]          imem_hsize,
    output logic [2:0]          imem_hburst,
    output logic                imem_hmastlock,
    output logic [3:0]          imem_hprot,
    output logic                imem_hwrite,
    output logic [32*NINST-1:0] imem_hwdata,
    input  logic [32*NINST-1:0] imem_hrdata,
    input  logic                imem_hready,
    input  logic                imem_hresp
`ifdef IFU_AHB_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_kill_cnt
`endif
);
    localparam int BW = 32 * NINST;
    localparam int OW = $clog2(4 * NINST);
    localparam int AW = $clog2(IFB_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] STEP = 32'(4 * NINST);

    typedef enum logic {RUN, HALT} state_t;
    state_t state, state_nxt;

    logic [31:0]      r_pc, base, r_jmp_pend;
    logic             r_no_fetch, r_hold, r_err_pend, r_jmp_pend_v;
    logic             r_dp_valid, r_dp_kill;
    logic [31:0]      r_dp_addr;
    logic [NINST-1:0] r_dp_mask, lane_mask;

    logic [NINST-1:0] m_mask [IFB_DEPTH];
    logic [BW-1:0]    m_data [IFB_DEPTH];
    logic [31:0]      m_addr [IFB_DEPTH];
    logic             m_err  [IFB_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;

    logic fetch_en, nonseq, accept, dp_done, err_first, stalled, drop, push, pop, has;

    assign base      = {r_pc[31:OW], OW'(0)};
    assign fetch_en  = !r_no_fetch && !r_err_pend && state == RUN &&
                       (int'(count) + int'(r_dp_valid) + 1 <= IFB_DEPTH);
    assign nonseq    = !rst && (fetch_en || r_hold);
    assign accept    = nonseq && imem_hready;
    assign dp_done   = r_dp_valid && imem_hready;
    // The first cycle of an error response abandons any address we are holding.
    assign err_first = r_dp_valid && imem_hresp && !imem_hready;
    assign stalled   = nonseq && !imem_hready && !err_first;
    assign drop      = r_dp_kill || ifu_take_jmp;
    assign push      = dp_done && !drop;
    assign pop       = use_out && count != '0;
    assign has       = count != '0;

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NINST; i++)
            lane_mask[i] = i >= int'(r_pc[OW-1:0] >> 2);
    end

    assign imem_haddr     = base;
    assign imem_htrans    = {nonseq, 1'b0};
    assign imem_hsize     = 3'(OW);
    assign imem_hburst    = 3'b000;
    assign imem_hmastlock = 1'b0;
    assign imem_hprot     = 4'b0010;
    assign imem_hwrite    = 1'b0;
    assign imem_hwdata    = '0;

    assign out_valid = has ? m_mask[rd_ptr] : '0;
    assign out_inst  = has ? m_data[rd_ptr] : '0;
    assign out_addr  = has ? m_addr[rd_ptr] : '0;
    assign out_err   = has && m_err[rd_ptr];

    always_comb begin
        state_nxt = state;
        if (ifu_take_jmp)
            state_nxt = RUN;
        else if (dp_done && imem_hresp && !r_dp_kill)
            state_nxt = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= rst_vec;
            r_no_fetch   <= 1'b1;
            r_hold       <= 1'b0;
            r_err_pend   <= 1'b0;
            r_jmp_pend_v <= 1'b0;
            r_jmp_pend   <= '0;
            r_dp_valid   <= 1'b0;
            r_dp_kill    <= 1'b0;
            r_dp_addr    <= '0;
            r_dp_mask    <= '0;
        end else begin
            r_no_fetch <= 1'b0;
            r_hold     <= stalled;
            r_err_pend <= err_first || (r_err_pend && !dp_done);
            if (accept)
                r_pc <= ifu_take_jmp ? ifu_jmp_addr : r_jmp_pend_v ? r_jmp_pend : base + STEP;
            else if (ifu_take_jmp && !stalled)
                r_pc <= ifu_jmp_addr;
            else if (err_first && r_jmp_pend_v)
                r_pc <= r_jmp_pend;
            // A jump that arrives while an address is held waits for that transfer to finish.
            if (ifu_take_jmp && stalled) begin
                r_jmp_pend_v <= 1'b1;
                r_jmp_pend   <= ifu_jmp_addr;
            end else if (accept || err_first) begin
                r_jmp_pend_v <= 1'b0;
            end
            if (accept) begin
                r_dp_valid <= 1'b1;
                r_dp_addr  <= base;
                r_dp_mask  <= lane_mask;
                r_dp_kill  <= ifu_take_jmp || r_jmp_pend_v;
            end else if (dp_done) begin
                r_dp_valid <= 1'b0;
                r_dp_kill  <= 1'b0;
            end else if (ifu_take_jmp) begin
                r_dp_kill  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || ifu_take_jmp) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            m_mask[wr_ptr] <= imem_hresp ? '0 : r_dp_mask;
            m_data[wr_ptr] <= imem_hrdata;
            m_addr[wr_ptr] <= r_dp_addr;
            m_err[wr_ptr]  <= imem_hresp;
        end
    end

`ifdef IFU_AHB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_kill_cnt  <= '0;
        end else begin
            if (accept)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (dp_done && drop) perf_kill_cnt  <= perf_kill_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ifu_ahb.sv
// tb_ifu_ahb: table-driven check of ifu_ahb fetch, jump, stall, backpressure, reset and error handling.
module tb_ifu_ahb;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] rst_vec = 32'h1000;
    logic        jmp = 1'b0, use_out = 1'b1, hready = 1'b1, hresp = 1'b0;
    logic [31:0] jaddr = '0;
    logic [1:0]  out_valid;
    logic [63:0] out_inst, hrdata, hwdata;
    logic [31:0] out_addr, haddr;
    logic        out_err, hmastlock, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] dph_addr = '0;
    int checks = 0, errors = 0;

    ifu_ahb #(.NINST(2), .IFB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rst_vec(rst_vec), .ifu_take_jmp(jmp), .ifu_jmp_addr(jaddr),
        .use_out(use_out), .out_valid(out_valid), .out_inst(out_inst), .out_addr(out_addr),
        .out_err(out_err), .imem_haddr(haddr), .imem_htrans(htrans), .imem_hsize(hsize),
        .imem_hburst(hburst), .imem_hmastlock(hmastlock), .imem_hprot(hprot),
        .imem_hwrite(hwrite), .imem_hwdata(hwdata), .imem_hrdata(hrdata),
        .imem_hready(hready), .imem_hresp(hresp)
    );

    always #5 clk = ~clk;

    // Slave model: each lane returns its own word address as the instruction.
    always @(posedge clk) if (htrans == 2'b10 && hready) dph_addr <= haddr;
    assign hrdata = {dph_addr + 32'd4, dph_addr};

    typedef struct {
        logic        jmp;
        logic [31:0] ja;
        logic        rdy;
        logic        use_o;
        logic [1:0]  tr;
        logic [31:0] ad;
        logic [1:0]  v;
        logic [31:0] oa;
    } vec_t;
    vec_t tbl [22];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h1000, 2'd0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h1008, 2'd0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h1010, 2'd3, 32'h1000};
        tbl[3]  = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h1018, 2'd3, 32'h1008};
        tbl[4]  = '{1'b1, 32'h2004, 1'b1, 1'b1, 2'd2, 32'h2000, 2'd0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h2008, 2'd0, 32'h0};
        tbl[6]  = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h2010, 2'd2, 32'h2000};
        tbl[7]  = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h2018, 2'd3, 32'h2008};
        tbl[8]  = '{1'b1, 32'h3000, 1'b0, 1'b1, 2'd2, 32'h2018, 2'd0, 32'h0};
        tbl[9]  = '{1'b0, 32'h0,    1'b0, 1'b1, 2'd2, 32'h2018, 2'd0, 32'h0};
        tbl[10] = '{1'b0, 32'h0,    1'b0, 1'b1, 2'd2, 32'h2018, 2'd0, 32'h0};
        tbl[11] = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h3000, 2'd0, 32'h0};
        tbl[12] = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h3008, 2'd0, 32'h0};
        tbl[13] = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h3010, 2'd3, 32'h3000};
        tbl[14] = '{1'b0, 32'h0,    1'b1, 1'b0, 2'd2, 32'h3018, 2'd3, 32'h3000};
        tbl[15] = '{1'b0, 32'h0,    1'b1, 1'b0, 2'd0, 32'h0,    2'd3, 32'h3000};
        tbl[16] = '{1'b0, 32'h0,    1'b1, 1'b0, 2'd0, 32'h0,    2'd3, 32'h3000};
        tbl[17] = '{1'b0, 32'h0,    1'b1, 1'b0, 2'd0, 32'h0,    2'd3, 32'h3000};
        tbl[18] = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h3020, 2'd3, 32'h3008};
        tbl[19] = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h3028, 2'd3, 32'h3010};
        tbl[20] = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h3030, 2'd3, 32'h3018};
        tbl[21] = '{1'b0, 32'h0,    1'b1, 1'b1, 2'd2, 32'h3038, 2'd3, 32'h3020};

        step();
        step();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        chk("rst_htrans", 64'(htrans), 64'd0);
        chk("hsize", 64'(hsize), 64'd3);
        chk("hprot", 64'(hprot), 64'h2);
        rst = 1'b0;
        #1;
        chk("post_rst_idle", 64'(htrans), 64'd0);

        for (int i = 0; i < 22; i++) begin
            jmp = tbl[i].jmp;
            jaddr = tbl[i].ja;
            hready = tbl[i].rdy;
            use_out = tbl[i].use_o;
            step();
            chk($sformatf("htrans[%0d]", i), 64'(htrans), 64'(tbl[i].tr));
            if (tbl[i].tr == 2'd2) chk($sformatf("haddr[%0d]", i), 64'(haddr), 64'(tbl[i].ad));
            chk($sformatf("valid[%0d]", i), 64'(out_valid), 64'(tbl[i].v));
            chk($sformatf("err[%0d]", i), 64'(out_err), 64'd0);
            if (tbl[i].v != 2'd0) begin
                chk($sformatf("oaddr[%0d]", i), 64'(out_addr), 64'(tbl[i].oa));
                chk($sformatf("inst[%0d]", i), out_inst, {tbl[i].oa + 32'd4, tbl[i].oa});
            end
        end
        jmp = 1'b0;
        hready = 1'b1;
        use_out = 1'b1;

        // Reset while a data phase is outstanding.
        rst = 1'b1;
        #1;
        chk("rst_cycle_idle", 64'(htrans), 64'd0);
        step();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_err", 64'(out_err), 64'd0);
        chk("mid_rst_idle1", 64'(htrans), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_idle2", 64'(htrans), 64'd0);
        step();
        chk("resume_htrans", 64'(htrans), 64'd2);
        chk("resume_haddr", 64'(haddr), 64'h1000);

        // Error response on the 0x1008 block.
        step();
        chk("e_haddr1008", 64'(haddr), 64'h1008);
        step();
        chk("e_valid1000", 64'(out_valid), 64'd3);
        chk("e_addr1000", 64'(out_addr), 64'h1000);
        hready = 1'b0;
        hresp = 1'b1;
        step();
        chk("e_idle_first", 64'(htrans), 64'd0);
        chk("e_valid_empty", 64'(out_valid), 64'd0);
        hready = 1'b1;
        step();
        hresp = 1'b0;
        chk("e_out_err", 64'(out_err), 64'd1);
        chk("e_out_valid0", 64'(out_valid), 64'd0);
        chk("e_out_addr", 64'(out_addr), 64'h1008);
        chk("e_idle_halt", 64'(htrans), 64'd0);
        step();
        chk("e_err_popped", 64'(out_err), 64'd0);
        chk("e_halt_idle1", 64'(htrans), 64'd0);
        step();
        chk("e_halt_idle2", 64'(htrans), 64'd0);
        jmp = 1'b1;
        jaddr = 32'h1000;
        step();
        jmp = 1'b0;
        chk("e_jmp_htrans", 64'(htrans), 64'd2);
        chk("e_jmp_haddr", 64'(haddr), 64'h1000);
        step();
        step();
        chk("e_refetch_valid", 64'(out_valid), 64'd3);
        chk("e_refetch_addr", 64'(out_addr), 64'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
